wbu_scoreboard: RTL and testbench

Writeback and scoreboard stage sitting directly upstream of the integer register file's write port. It tracks which architectural registers have an in-flight write, stalls issue on RAW/WAW hazards, and arbitrates results from the execute unit (EXU) and load/store unit (LSU). The single accepted result per cycle is registered and driven to the register file as `rf_wen`/`rf_waddr`/`rf_wdata`.

---
 rtl/wbu_scoreboard_if.sv | 51 +++++
 rtl/wbu_scoreboard.sv | 88 ++++++++
 tb/tb_wbu_scoreboard.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wbu_scoreboard_if.sv
// wbu_scoreboard_if
//   Bundles the issue, EXU result, LSU result, register-file write and
//   scoreboard status signals of the writeback/scoreboard stage.
//   master : the surrounding pipeline (drives issue and results)
//   slave  : wbu_scoreboard (drives ready, register-file write, status)
interface wbu_scoreboard_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic                  issue_valid;
    logic                  issue_rd_wen;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic [ADDR_WIDTH-1:0] issue_rs1;
    logic [ADDR_WIDTH-1:0] issue_rs2;
    logic                  issue_ready;

    logic                  exu_valid;
    logic [ADDR_WIDTH-1:0] exu_rd;
    logic [DATA_WIDTH-1:0] exu_data;
    logic                  exu_ready;

    logic                  lsu_valid;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  lsu_ready;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    logic [NREG-1:0]       sb_busy;
    logic                  sb_err;

    modport master (
        output issue_valid, issue_rd_wen, issue_rd, issue_rs1, issue_rs2,
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_ready, exu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata, sb_busy, sb_err
    );

    modport slave (
        input  issue_valid, issue_rd_wen, issue_rd, issue_rs1, issue_rs2,
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_ready, exu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata, sb_busy, sb_err
    );
endinterface

// File: rtl/wbu_scoreboard.sv
// wbu_scoreboard
//   Writeback and scoreboard stage in front of the integer register file.
//   Tracks in-flight writes per register, stalls issue on RAW/WAW hazards,
//   arbitrates EXU/LSU results (LSU has priority) and registers the single
//   accepted result onto the register-file write port.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : wbu_scoreboard_if.slave (issue, exu, lsu, rf write, sb status)
module wbu_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64
) (
    input logic             clk,
    input logic             rst_n,
    wbu_scoreboard_if.slave bus
);
    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       busy_q, busy_d;
    logic [NREG-1:0]       set_vec, clr_vec;
    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic                  err_q, err_d;

    logic                  raw_haz, waw_haz, issue_fire;
    logic                  res_valid, res_wr;
    logic [ADDR_WIDTH-1:0] res_rd;
    logic [DATA_WIDTH-1:0] res_data;

    // Hazards look only at registered busy: a clear in flight is not bypassed.
    always_comb begin
        raw_haz = ((bus.issue_rs1 != '0) && busy_q[bus.issue_rs1]) ||
                  ((bus.issue_rs2 != '0) && busy_q[bus.issue_rs2]);
        waw_haz = bus.issue_rd_wen && (bus.issue_rd != '0) && busy_q[bus.issue_rd];
    end

    assign bus.issue_ready = !(raw_haz || waw_haz);
    assign issue_fire      = bus.issue_valid && bus.issue_ready;

    assign bus.lsu_ready = 1'b1;
    assign bus.exu_ready = !bus.lsu_valid;

    always_comb begin
        res_valid = bus.lsu_valid || bus.exu_valid;
        res_rd    = bus.lsu_valid ? bus.lsu_rd   : bus.exu_rd;
        res_data  = bus.lsu_valid ? bus.lsu_data : bus.exu_data;
        res_wr    = res_valid && (res_rd != '0);
        err_d     = err_q || (res_wr && !busy_q[res_rd]);
    end

    // Clear is applied before set so a same-index collision leaves the bit set.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_fire && bus.issue_rd_wen && (bus.issue_rd != '0))
            set_vec[bus.issue_rd] = 1'b1;
        if (rf_wen_q)
            clr_vec[rf_waddr_q] = 1'b1;
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            rf_wen_q <= res_wr;
            // An rd = 0 result is consumed but leaves address/data untouched.
            if (res_wr) begin
                rf_waddr_q <= res_rd;
                rf_wdata_q <= res_data;
            end
            err_q <= err_d;
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.sb_busy  = busy_q;
    assign bus.sb_err   = err_q;
endmodule

// File: tb/tb_wbu_scoreboard.sv
// tb_wbu_scoreboard
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a reference model of pending registers and the expected write port.
module tb_wbu_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wbu_scoreboard_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

    wbu_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which registers await a result, and the expected write port.
    bit          pend [32];
    bit          m_wen;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        bit haz;
        haz = 1'b0;
        if (bus.issue_rs1 != 0 && pend[bus.issue_rs1]) haz = 1'b1;
        if (bus.issue_rs2 != 0 && pend[bus.issue_rs2]) haz = 1'b1;
        if (bus.issue_rd_wen && bus.issue_rd != 0 && pend[bus.issue_rd]) haz = 1'b1;
        return !haz;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_err  = 1'b0;
    endtask

    task automatic check_model();
        chk("issue_ready", {63'd0, bus.issue_ready}, {63'd0, m_ready()});
        chk("exu_ready",   {63'd0, bus.exu_ready},   {63'd0, !bus.lsu_valid});
        chk("lsu_ready",   {63'd0, bus.lsu_ready},   64'd1);
        chk("rf_wen",      {63'd0, bus.rf_wen},      {63'd0, m_wen});
        chk("rf_waddr",    {59'd0, bus.rf_waddr},    {59'd0, m_addr});
        chk("rf_wdata",    bus.rf_wdata,             m_data);
        chk("sb_busy",     {32'd0, bus.sb_busy},     {32'd0, pend_vec()});
        chk("sb_err",      {63'd0, bus.sb_err},      {63'd0, m_err});
    endtask

    // Advance the model by one clock edge using the inputs present now.
    task automatic model_step();
        bit          fire, acc, err_new;
        logic [4:0]  ard;
        logic [63:0] adat;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fire    = bus.issue_valid && m_ready();
        acc     = bus.lsu_valid || bus.exu_valid;
        ard     = bus.lsu_valid ? bus.lsu_rd : bus.exu_rd;
        adat    = bus.lsu_valid ? bus.lsu_data : bus.exu_data;
        err_new = acc && ard != 0 && !pend[ard];
        if (m_wen) pend[m_addr] = 1'b0;
        if (fire && bus.issue_rd_wen && bus.issue_rd != 0) pend[bus.issue_rd] = 1'b1;
        m_err = m_err || err_new;
        if (acc && ard != 0) begin
            m_wen  = 1'b1;
            m_addr = ard;
            m_data = adat;
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic tick();
        #1;
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0; bus.issue_rd_wen = 1'b0;
        bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.issue_valid = 1'b1; bus.issue_rd_wen = 1'b1;
        bus.issue_rd = rd; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
    endtask

    task automatic exu(input logic [4:0] rd, input logic [63:0] d);
        bus.exu_valid = 1'b1; bus.exu_rd = rd; bus.exu_data = d;
    endtask

    task automatic lsu(input logic [4:0] rd, input logic [63:0] d);
        bus.lsu_valid = 1'b1; bus.lsu_rd = rd; bus.lsu_data = d;
    endtask

    function automatic logic [4:0] pick_rd();
        logic [4:0] r;
        for (int t = 0; t < 8; t++) begin
            r = 5'($urandom_range(1, 7));
            if (pend[r]) return r;
        end
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        bit exu_lost;

        // Reset held two cycles with traffic present.
        idle();
        rst_n = 1'b0;
        issue(5'd5, 5'd0, 5'd0);
        exu(5'd5, 64'h55);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        idle();
        #1;
        chk("reset_busy",   {32'd0, bus.sb_busy}, 64'd0);
        chk("reset_rf_wen", {63'd0, bus.rf_wen},  64'd0);
        chk("reset_err",    {63'd0, bus.sb_err},  64'd0);
        tick();

        // RAW stall on x3.
        issue(5'd3, 5'd0, 5'd0); tick();
        issue(5'd4, 5'd3, 5'd0); #1;
        chk("raw_stall0", {63'd0, bus.issue_ready}, 64'd0);
        tick();
        exu(5'd3, 64'hDEAD_BEEF_0000_0001); #1;
        chk("raw_stall1", {63'd0, bus.issue_ready}, 64'd0);
        tick();
        bus.exu_valid = 1'b0; #1;
        chk("raw_wen",    {63'd0, bus.rf_wen},      64'd1);
        chk("raw_waddr",  {59'd0, bus.rf_waddr},    64'd3);
        chk("raw_wdata",  bus.rf_wdata,             64'hDEAD_BEEF_0000_0001);
        chk("raw_stall2", {63'd0, bus.issue_ready}, 64'd0);
        tick();
        #1;
        chk("raw_release", {63'd0, bus.issue_ready}, 64'd1);
        tick();
        idle(); exu(5'd4, 64'h4444); tick();
        idle(); tick(); tick();

        // Arbitration: LSU x7 beats EXU x8.
        issue(5'd7, 5'd0, 5'd0); tick();
        issue(5'd8, 5'd0, 5'd0); tick();
        idle();
        lsu(5'd7, 64'h7777); exu(5'd8, 64'h8888); #1;
        chk("arb_exu_ready0", {63'd0, bus.exu_ready}, 64'd0);
        tick();
        bus.lsu_valid = 1'b0; #1;
        chk("arb_waddr1", {59'd0, bus.rf_waddr}, 64'd7);
        tick();
        bus.exu_valid = 1'b0; #1;
        chk("arb_waddr2", {59'd0, bus.rf_waddr}, 64'd8);
        chk("arb_wdata2", bus.rf_wdata,          64'h8888);
        tick();
        #1;
        chk("arb_busy78", {62'd0, bus.sb_busy[8:7]}, 64'd0);
        tick();

        // x0 destination and x0 source.
        issue(5'd0, 5'd0, 5'd0); #1;
        chk("x0_ready", {63'd0, bus.issue_ready}, 64'd1);
        tick();
        idle(); exu(5'd0, 64'h1234); tick();
        idle(); #1;
        chk("x0_busy", {63'd0, bus.sb_busy[0]}, 64'd0);
        chk("x0_wen",  {63'd0, bus.rf_wen},     64'd0);
        chk("x0_err",  {63'd0, bus.sb_err},     64'd0);
        tick();

        // WAW on x10.
        issue(5'd10, 5'd0, 5'd0); tick();
        #1;
        chk("waw_stall", {63'd0, bus.issue_ready}, 64'd0);
        tick();
        exu(5'd10, 64'hA0); tick();
        bus.exu_valid = 1'b0; tick();
        #1;
        chk("waw_release", {63'd0, bus.issue_ready}, 64'd1);
        tick();
        idle(); exu(5'd10, 64'hA1); tick();
        idle(); tick(); tick();

        // Result for a never-issued register.
        lsu(5'd12, 64'hC0FFEE); tick();
        idle(); #1;
        chk("err_wen",   {63'd0, bus.rf_wen},   64'd1);
        chk("err_waddr", {59'd0, bus.rf_waddr}, 64'd12);
        chk("err_flag",  {63'd0, bus.sb_err},   64'd1);
        tick(); tick();

        // Reset while x4/x9 are pending and x4 result is accepted.
        issue(5'd4, 5'd0, 5'd0); tick();
        issue(5'd9, 5'd0, 5'd0); tick();
        idle(); exu(5'd4, 64'h4); rst_n = 1'b0; tick();
        rst_n = 1'b1; idle(); #1;
        chk("rst_mid_wen",  {63'd0, bus.rf_wen},  64'd0);
        chk("rst_mid_busy", {32'd0, bus.sb_busy}, 64'd0);
        tick();

        // Randomized traffic on registers 0..7.
        exu_lost = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            bus.issue_valid  = ($urandom_range(0, 1) == 1);
            bus.issue_rd_wen = ($urandom_range(0, 3) != 0);
            bus.issue_rd     = 5'($urandom_range(0, 7));
            bus.issue_rs1    = 5'($urandom_range(0, 7));
            bus.issue_rs2    = 5'($urandom_range(0, 7));
            if (!exu_lost) begin
                bus.exu_valid = ($urandom_range(0, 2) == 0);
                bus.exu_rd    = pick_rd();
                bus.exu_data  = {$urandom, $urandom};
            end
            bus.lsu_valid = ($urandom_range(0, 3) == 0);
            bus.lsu_rd    = pick_rd();
            bus.lsu_data  = {$urandom, $urandom};
            exu_lost = bus.exu_valid && bus.lsu_valid && rst_n;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
